rgb_breath_pwm: RTL and testbench

Multi-channel successor to the single-channel breathing PWM. It drives CH LED channels from one shared frame counter. Each channel has its own duty ramp, either auto-reversing (triangle breathing) or direction-steered by external flags. The BP button selects one of NMODE breathing periods, applied glitch-free at frame boundaries. The block sits between the top-level button/flag inputs and the RGB LED pins.

---
 rtl/rgb_breath_pwm_pkg.sv | 25 ++
 rtl/rgb_breath_pwm_chan.sv | 79 +++++++
 rtl/rgb_breath_pwm.sv | 100 ++++++++++
 tb/tb_rgb_breath_pwm.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_breath_pwm_pkg.sv
// rgb_pwm_pkg: shared mode type and period/phase helpers for the
// multi-channel breathing PWM.
package rgb_pwm_pkg;

    localparam int unsigned NMODE_DEF = 4;
    localparam int unsigned MODE_W    = $clog2(NMODE_DEF);

    typedef logic [MODE_W-1:0] mode_t;

    function automatic int unsigned period_of(
        input int unsigned mode,
        input int unsigned base
    );
        return base * (mode + 1);
    endfunction

    function automatic int unsigned reset_phase(
        input int unsigned idx,
        input int unsigned base,
        input int unsigned ch
    );
        return (idx * base) / ch;
    endfunction

endpackage

// File: rtl/rgb_breath_pwm_chan.sv
// breath_chan: one channel's duty ramp, period clamp, reach-top strobe
// and registered PWM compare against the shared frame counter.
module breath_chan
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter logic [W-1:0] RST_D = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_auto,
    input  logic         i_flag,
    input  logic         i_frame_end,
    input  logic         i_apply,
    input  logic [W-1:0] i_cnt,
    input  logic [W-1:0] i_p,
    input  logic [W-1:0] i_newp,
    output logic         o_pwm,
    output logic         o_stt
);

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    logic [W-1:0] r_d;
    logic         r_dir;
    logic         r_pwm;
    logic         r_stt;

    logic [W-1:0] w_pm1;
    logic [W-1:0] w_newpm1;
    logic [W-1:0] w_upd;
    logic [W-1:0] w_next;
    logic         w_dir_next;
    logic         w_hit;

    always_comb begin
        w_pm1      = i_p - W'(1);
        w_newpm1   = i_newp - W'(1);
        w_upd      = r_d;
        w_dir_next = r_dir;
        if (i_auto) begin
            if (r_dir == DIR_UP) begin
                if (r_d == w_pm1) w_dir_next = DIR_DN;
                else              w_upd      = r_d + W'(1);
            end else begin
                if (r_d == '0) w_dir_next = DIR_UP;
                else           w_upd      = r_d - W'(1);
            end
        end else if (i_flag) begin
            w_upd = (r_d == w_pm1) ? '0 : r_d + W'(1);
        end else begin
            w_upd = (r_d == '0) ? w_pm1 : r_d - W'(1);
        end
        // update uses the old period, clamp uses the new one
        w_next = i_frame_end ? w_upd : r_d;
        if (i_apply && (w_next > w_newpm1)) w_next = w_newpm1;
        w_hit = i_frame_end && (w_upd == w_pm1) && (r_d != w_pm1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d   <= RST_D;
            r_dir <= DIR_UP;
            r_pwm <= 1'b0;
            r_stt <= 1'b0;
        end else begin
            r_d   <= w_next;
            r_dir <= i_frame_end ? w_dir_next : r_dir;
            r_pwm <= i_en & (i_cnt < r_d);
            r_stt <= w_hit;
        end
    end

    assign o_pwm = r_pwm;
    assign o_stt = r_stt;

endmodule

// File: rtl/rgb_breath_pwm.sv
// rgb_breath_pwm: CH breathing PWM channels sharing one frame counter,
// with a button-selected period applied only at frame boundaries.
module rgb_breath_pwm
    import rgb_pwm_pkg::*;
#(
    parameter  int unsigned CH          = 3,
    parameter  int unsigned W           = 16,
    parameter  int unsigned NMODE       = NMODE_DEF,
    parameter  int unsigned PERIOD_BASE = 1500,
    localparam int unsigned MW          = (NMODE > 1) ? $clog2(NMODE) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_bp,
    input  logic          i_auto,
    input  logic [CH-1:0] i_flag,
    output logic [CH-1:0] o_pwm,
    output logic [CH-1:0] o_stt,
    output logic [MW-1:0] o_mode
);

    logic          r_bp_s1;
    logic          r_bp_s2;
    logic          r_bp_q;
    logic [MW-1:0] r_pend;
    logic [MW-1:0] r_mode;
    logic [W-1:0]  r_cnt;

    logic          w_bp_rise;
    logic [MW-1:0] w_pend_inc;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_pm1;
    logic [W-1:0]  w_newp;
    logic          w_frame_end;
    logic          w_apply;

    assign w_bp_rise  = r_bp_s2 & ~r_bp_q;
    assign w_pend_inc = (r_pend == MW'(NMODE - 1)) ? '0 : r_pend + MW'(1);
    assign w_p        = W'(period_of(32'(r_mode), PERIOD_BASE));
    assign w_newp     = W'(period_of(32'(r_pend), PERIOD_BASE));
    assign w_pm1      = w_p - W'(1);

    // >= also ends a frame whose count outran a period shrunk while frozen
    assign w_frame_end = i_en & (r_cnt >= w_pm1);
    assign w_apply     = w_frame_end | ~i_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bp_s1 <= 1'b0;
            r_bp_s2 <= 1'b0;
            r_bp_q  <= 1'b0;
        end else begin
            r_bp_s1 <= i_bp;
            r_bp_s2 <= r_bp_s1;
            r_bp_q  <= r_bp_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_mode <= '0;
        end else begin
            if (w_apply)   r_mode <= r_pend;
            if (w_bp_rise) r_pend <= w_pend_inc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_frame_end ? '0 : r_cnt + W'(1);
        end
    end

    assign o_mode = r_mode;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        breath_chan #(
            .W     (W),
            .RST_D (W'(reset_phase(gi, PERIOD_BASE, CH)))
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_en        (i_en),
            .i_auto      (i_auto),
            .i_flag      (i_flag[gi]),
            .i_frame_end (w_frame_end),
            .i_apply     (w_apply),
            .i_cnt       (r_cnt),
            .i_p         (w_p),
            .i_newp      (w_newp),
            .o_pwm       (o_pwm[gi]),
            .o_stt       (o_stt[gi])
        );
    end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// tb_rgb_breath_pwm: table-driven frame checks, directed corner sequences
// and a cycle-by-cycle reference model under random stimulus.
module tb_rgb_breath_pwm;

    localparam int CH    = 3;
    localparam int W     = 8;
    localparam int NMODE = 4;
    localparam int PB    = 4;

    typedef struct {
        bit       rst;
        bit       au;
        bit [2:0] fl;
        int       e0;
        int       e1;
        int       e2;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b1;
    logic          bp    = 1'b0;
    logic          auto_ = 1'b1;
    logic [CH-1:0] flag  = '0;
    logic [CH-1:0] pwm;
    logic [CH-1:0] stt;
    logic [1:0]    mode;

    int checks   = 0;
    int failures = 0;
    bit dyn      = 1'b0;
    int hc[CH];
    int sc0;

    // reference model state
    int m_cnt, m_mode, m_pend;
    int m_d[CH];
    bit m_dir[CH];
    bit m_pwm[CH];
    bit m_stt[CH];
    bit m_sync[3];

    always #5 clk = ~clk;

    rgb_breath_pwm #(
        .CH          (CH),
        .W           (W),
        .NMODE       (NMODE),
        .PERIOD_BASE (PB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_bp    (bp),
        .i_auto  (auto_),
        .i_flag  (flag),
        .o_pwm   (pwm),
        .o_stt   (stt),
        .o_mode  (mode)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_cnt  = 0;
        m_mode = 0;
        m_pend = 0;
        for (int i = 0; i < CH; i++) begin
            m_d[i]   = (i * PB) / CH;
            m_dir[i] = 1'b1;
            m_pwm[i] = 1'b0;
            m_stt[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) m_sync[i] = 1'b0;
    endtask

    task automatic m_step();
        int p, np, nd;
        bit fe, ap, rise;
        p    = PB * (m_mode + 1);
        np   = PB * (m_pend + 1);
        fe   = en && (m_cnt >= p - 1);
        ap   = fe || !en;
        rise = m_sync[1] && !m_sync[2];
        for (int i = 0; i < CH; i++) begin
            m_pwm[i] = en && (m_cnt < m_d[i]);
            nd = m_d[i];
            if (fe) begin
                if (auto_) begin
                    if (m_dir[i]) begin
                        if (nd == p - 1) m_dir[i] = 1'b0;
                        else nd = nd + 1;
                    end else begin
                        if (nd == 0) m_dir[i] = 1'b1;
                        else nd = nd - 1;
                    end
                end else begin
                    nd = flag[i] ? (nd + 1) % p : (nd + p - 1) % p;
                end
            end
            m_stt[i] = fe && (nd == p - 1) && (m_d[i] != p - 1);
            if (ap && nd > np - 1) nd = np - 1;
            m_d[i] = nd;
        end
        if (en) m_cnt = fe ? 0 : m_cnt + 1;
        if (ap) m_mode = m_pend;
        if (rise) m_pend = (m_pend + 1) % NMODE;
        m_sync[2] = m_sync[1];
        m_sync[1] = m_sync[0];
        m_sync[0] = bp;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        logic [7:0] act, exp;
        forever begin
            @(negedge clk);
            act = {pwm, stt, mode};
            exp = '0;
            for (int i = 0; i < CH; i++) begin
                exp[5 + i] = m_pwm[i];
                exp[2 + i] = m_stt[i];
            end
            exp[1:0] = 2'(m_mode);
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_cycle t=%0t actual pwm/stt/mode=%b required=%b",
                         $time, act, exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        if (dyn)
            for (int i = 0; i < CH; i++) flag[i] = (m_d[i] < 8);
    endtask

    task automatic win(input int len);
        for (int i = 0; i < CH; i++) hc[i] = 0;
        repeat (len) begin
            tick();
            for (int i = 0; i < CH; i++) hc[i] += int'(pwm[i]);
            sc0 += int'(stt[0]);
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic press_wait(input int target, input int budget,
                              output int lat);
        bp  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 3) bp = 1'b0;
        end while (mode != 2'(target) && lat < budget);
        bp = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        int lat, n;
        bit ok;

        tbl[0]  = '{1, 1, 3'b000, 0, 1, 2};
        tbl[1]  = '{0, 1, 3'b000, 1, 2, 3};
        tbl[2]  = '{0, 1, 3'b000, 2, 3, 3};
        tbl[3]  = '{0, 1, 3'b000, 3, 3, 2};
        tbl[4]  = '{0, 1, 3'b000, 3, 2, 1};
        tbl[5]  = '{0, 1, 3'b000, 2, 1, 0};
        tbl[6]  = '{0, 1, 3'b000, 1, 0, 0};
        tbl[7]  = '{0, 1, 3'b000, 0, 0, 1};
        tbl[8]  = '{0, 1, 3'b000, 0, 1, 2};
        tbl[9]  = '{0, 1, 3'b000, 1, 2, 3};
        tbl[10] = '{1, 0, 3'b001, 0, 1, 2};
        tbl[11] = '{0, 0, 3'b001, 1, 0, 1};
        tbl[12] = '{0, 0, 3'b001, 2, 3, 0};
        tbl[13] = '{0, 0, 3'b001, 3, 2, 3};
        tbl[14] = '{0, 0, 3'b001, 0, 1, 2};

        sc0 = 0;
        for (int v = 0; v < 15; v++) begin
            if (tbl[v].rst) do_reset();
            auto_ = tbl[v].au;
            flag  = tbl[v].fl;
            win(PB);
            chk($sformatf("tbl%0d_ch0", v), hc[0], tbl[v].e0);
            chk($sformatf("tbl%0d_ch1", v), hc[1], tbl[v].e1);
            chk($sformatf("tbl%0d_ch2", v), hc[2], tbl[v].e2);
            if (v == 9) chk("t1_stt0_pulses", sc0, 1);
        end

        // single press at frame start: applied at the next boundary
        press_wait(1, 20, lat);
        chk("t3_apply_latency", lat, 4);
        chk("t3_mode", mode, 1);
        win(8);
        chk("t3_w1_ch0", hc[0], 2);
        chk("t3_w1_ch1", hc[1], 3);
        chk("t3_w1_ch2", hc[2], 0);
        win(8);
        chk("t3_w2_ch0", hc[0], 3);
        chk("t3_w2_ch1", hc[1], 2);
        chk("t3_w2_ch2", hc[2], 7);

        // climb to mode 3, settle duties mid-range, then wrap to mode 0
        auto_ = 1'b0;
        dyn   = 1'b1;
        press_wait(2, 60, lat);
        chk("t4_mode2", mode, 2);
        press_wait(3, 60, lat);
        chk("t4_mode3", mode, 3);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 800) begin
            tick();
            n++;
            ok = 1'b1;
            for (int i = 0; i < CH; i++)
                if (m_d[i] < 6 || m_d[i] > 9) ok = 1'b0;
        end
        chk("t4_settle_timeout", ok, 1);
        press_wait(0, 60, lat);
        chk("t4_mode0", mode, 0);
        win(PB);
        chk("t4_clamp_ch0", hc[0], 3);
        chk("t4_clamp_ch1", hc[1], 3);
        chk("t4_clamp_ch2", hc[2], 3);
        dyn = 1'b0;

        // freeze mid-frame with a button edge inside the freeze
        repeat (2) tick();
        en  = 1'b0;
        bp  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("t5_pwm_low_%0d", k), pwm, 0);
            if (lat == 0 && mode == 2'd1) lat = k;
            if (k == 3) bp = 1'b0;
        end
        chk("t5_mode_latency", lat, 4);
        en = 1'b1;
        repeat (12) tick();

        // asynchronous reset mid-cycle
        auto_ = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pwm", pwm, 0);
        chk("t6_stt", stt, 0);
        chk("t6_mode", mode, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        win(PB);
        chk("t6_ch0", hc[0], 0);
        chk("t6_ch1", hc[1], 1);
        chk("t6_ch2", hc[2], 2);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            en   = ($urandom_range(0, 15) != 0);
            flag = 3'($urandom);
            if ($urandom_range(0, 63) == 0) auto_ = ~auto_;
            if ($urandom_range(0, 39) == 0) bp = ~bp;
        end
        bp = 1'b0;
        en = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
